memory_address_unit: RTL and testbench
======================================

Name: memory_address_unit

Overview:
- Parametrised successor to the processor's memory address register: holds the current memory address and drives it to memory every cycle.
- Besides direct load, it can post-increment or decrement by a stride and run self-timed bursts.
- An optional address window [lo, hi] wraps the address, so the block can act as a circular-buffer or stack pointer.
- Sits between the control unit and the memory address bus; the control unit sequences it through enables and handshake flags.

Parameters:
ADDR_W, 8, address width in bits
STRIDE, 1, step added or subtracted per increment, decrement or burst beat; 1 to 2^ADDR_W-1
LEN_W, 4, width of burst length input; maximum burst is 2^LEN_W-1 beats
WRAP_EN, 1, 1 = window wrap using MAU_win_lo/MAU_win_hi; 0 = natural modulo-2^ADDR_W wrap

Ports:
MAU_clk  input  1  clock; all state changes on rising edge
MAU_rst  input  1  synchronous, active-high reset
MAU_in  input  ADDR_W  address value to load
MAU_wr_en  input  1  load MAU_in; also aborts an active burst
MAU_inc_en  input  1  single post-increment by STRIDE (IDLE only)
MAU_dec_en  input  1  single post-decrement by STRIDE (IDLE only)
MAU_burst_start  input  1  start burst (IDLE only)
MAU_burst_len  input  LEN_W  burst beat count, sampled with MAU_burst_start
MAU_win_lo  input  ADDR_W  window low bound (WRAP_EN=1)
MAU_win_hi  input  ADDR_W  window high bound (WRAP_EN=1)
MAU_out  output  ADDR_W  current address, driven directly from the register
MAU_busy  output  1  high while in BURST
MAU_done  output  1  one-cycle pulse on burst completion
MAU_wrap  output  1  one-cycle pulse when the last update wrapped

Behaviour:
- Reset values:
  - MAU_out=0, MAU_busy=0, MAU_done=0, MAU_wrap=0.
  - State IDLE; remaining count 0.
  - Reset mid-burst aborts the burst with no done pulse.
- Latency: every update is visible on MAU_out in the cycle after the sampling edge. MAU_out is a plain copy of the register with no extra stage.
- Priority at each edge: MAU_rst > MAU_wr_en > state action.
- IDLE state action, in priority order: burst_start > inc_en > dec_en. inc_en and dec_en together means increment only.
- MAU_wr_en:
  - Loads MAU_in and forces IDLE.
  - In BURST it aborts the burst: busy drops next cycle, no done pulse.
  - The loaded value is not checked against the window; MAU_wrap=0.
- Burst start:
  - MAU_burst_start with len≠0 at edge E0 latches len and enters BURST; the address is unchanged at E0.
  - At edges E1..EN the address steps +STRIDE.
  - MAU_busy=1 from after E0 until after EN.
  - After EN: state IDLE, busy=0, done=1 for exactly one cycle.
  - Final MAU_out = A0+N·STRIDE, with wrap applied.
- Burst with len=0: start is ignored; no busy, no done.
- In BURST, inc_en, dec_en and burst_start are ignored; new starts are accepted the cycle done is high.
- Increment wrap (compute in ADDR_W+1 bits):
  - WRAP_EN=1 and lo≤hi: if addr+STRIDE > hi, next=lo and wrap=1.
  - WRAP_EN=0, or lo>hi: next=(addr+STRIDE) mod 2^ADDR_W, and wrap=carry-out.
- Decrement wrap:
  - WRAP_EN=1 and lo≤hi: if addr−STRIDE < lo (signed ADDR_W+1), next=hi and wrap=1.
  - Otherwise modulo arithmetic, with wrap=borrow.
- Window bounds are sampled combinationally at each step; changing them mid-burst is legal and affects subsequent beats.
- MAU_wrap is registered and high only in the cycle following a wrapping step; a held-idle cycle clears it.

Decomposition:
- Package mau_pkg:
  - State encoding localparams IDLE=1'b0, BURST=1'b1.
  - Shared helper constant for ADDR_W+1 compare width.
- Sub-module mau_step: combinational next-address and wrap-flag computation from addr, direction, STRIDE, lo, hi and WRAP_EN. It is instantiated once and shared by the single-step and burst paths.
- The top level holds the address register, state, remaining counter, and the done/wrap flag registers.

Test Plan:
- Reset then load: rst=1 for 1 cycle → MAU_out=0, flags 0. Then wr_en with MAU_in=8'h3C → MAU_out=8'h3C next cycle, MAU_wrap=0.
- Burst, STRIDE=4, WRAP_EN=1, lo=8'h10, hi=8'h1F: load 8'h10, start len=5 → MAU_out sequence 8'h14, 8'h18, 8'h1C, 8'h10 (wrap=1 that cycle), 8'h14. busy high 5 cycles; done pulses once with busy=0.
- Decrement wrap, STRIDE=1, lo=8'h20, hi=8'h2F: addr 8'h20, dec_en → MAU_out=8'h2F, wrap=1. inc_en → 8'h20 with wrap=1 (2F+1 > hi).
- Natural wrap, WRAP_EN=0: addr 8'hFF, inc_en → 8'h00, wrap=1. dec_en → 8'hFF, wrap=1.
- Abort and ignores: burst len=7 from 8'h00, wr_en with 8'h80 at beat 3 → MAU_out=8'h80, busy=0 next cycle, done never pulses. In a separate burst, inc_en held high → sequence unchanged. Burst len=0 → no busy, no done.
- Priority and reset: inc_en+dec_en together from 8'h05 → 8'h06. wr_en+burst_start together → load only, stays IDLE. rst mid-burst → MAU_out=0, busy=0, done=0.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory address unit.
package mau_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mau_state_e;

    // One extra bit holds the carry/borrow of an address step.
    localparam int CMP_EXTRA = 1;

    function automatic int cmp_width(input int addr_w);
        return addr_w + CMP_EXTRA;
    endfunction

endpackage

// File: rtl/mau_step.sv
// Combinational next-address and wrap-flag computation for one +/-STRIDE step.
module mau_step
    import mau_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int STRIDE  = 1,
    parameter int WRAP_EN = 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              dec_i,
    input  logic [ADDR_W-1:0] lo_i,
    input  logic [ADDR_W-1:0] hi_i,
    output logic [ADDR_W-1:0] next_o,
    output logic              wrap_o
);

    localparam int            CW       = cmp_width(ADDR_W);
    localparam logic [CW-1:0] STRIDE_X = CW'(STRIDE);
    localparam logic          WIN_CFG  = (WRAP_EN != 0);

    logic [CW-1:0] sum, diff, lo_x, hi_x;
    logic          win_en;

    assign sum    = {1'b0, addr_i} + STRIDE_X;
    assign diff   = {1'b0, addr_i} - STRIDE_X;
    assign lo_x   = {1'b0, lo_i};
    assign hi_x   = {1'b0, hi_i};
    // An inverted window (lo > hi) falls back to natural modulo wrap.
    assign win_en = WIN_CFG && (lo_i <= hi_i);

    always_comb begin
        next_o = sum[ADDR_W-1:0];
        wrap_o = 1'b0;
        if (!dec_i) begin
            if (win_en) begin
                if (sum > hi_x) begin
                    next_o = lo_i;
                    wrap_o = 1'b1;
                end else begin
                    next_o = sum[ADDR_W-1:0];
                end
            end else begin
                next_o = sum[ADDR_W-1:0];
                wrap_o = sum[ADDR_W];
            end
        end else begin
            if (win_en) begin
                if ($signed(diff) < $signed(lo_x)) begin
                    next_o = hi_i;
                    wrap_o = 1'b1;
                end else begin
                    next_o = diff[ADDR_W-1:0];
                end
            end else begin
                next_o = diff[ADDR_W-1:0];
                wrap_o = diff[ADDR_W];
            end
        end
    end

endmodule

// File: rtl/memory_address_unit.sv
// Memory address register with load, single step, self-timed bursts and window wrap.
module memory_address_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int STRIDE  = 1,
    parameter int LEN_W   = 4,
    parameter int WRAP_EN = 1
) (
    input  logic              MAU_clk,
    input  logic              MAU_rst,
    input  logic [ADDR_W-1:0] MAU_in,
    input  logic              MAU_wr_en,
    input  logic              MAU_inc_en,
    input  logic              MAU_dec_en,
    input  logic              MAU_burst_start,
    input  logic [LEN_W-1:0]  MAU_burst_len,
    input  logic [ADDR_W-1:0] MAU_win_lo,
    input  logic [ADDR_W-1:0] MAU_win_hi,
    output logic [ADDR_W-1:0] MAU_out,
    output logic              MAU_busy,
    output logic              MAU_done,
    output logic              MAU_wrap
);

    mau_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              done_q, wrap_q;

    logic [ADDR_W-1:0] step_next;
    logic              step_wrap, step_dec;

    // Bursts always count up; a lone dec_en only matters in IDLE.
    assign step_dec = (state_q == IDLE) && !MAU_inc_en && MAU_dec_en;

    mau_step #(
        .ADDR_W (ADDR_W),
        .STRIDE (STRIDE),
        .WRAP_EN(WRAP_EN)
    ) u_step (
        .addr_i(addr_q),
        .dec_i (step_dec),
        .lo_i  (MAU_win_lo),
        .hi_i  (MAU_win_hi),
        .next_o(step_next),
        .wrap_o(step_wrap)
    );

    always_ff @(posedge MAU_clk) begin
        if (MAU_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (MAU_wr_en) begin
            state_q <= IDLE;
            addr_q  <= MAU_in;
            rem_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MAU_burst_start && (MAU_burst_len != '0)) begin
                        state_q <= BURST;
                        rem_q   <= MAU_burst_len;
                    end else if (MAU_inc_en || MAU_dec_en) begin
                        addr_q <= step_next;
                        wrap_q <= step_wrap;
                    end
                end
                BURST: begin
                    addr_q <= step_next;
                    wrap_q <= step_wrap;
                    rem_q  <= rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MAU_out  = addr_q;
    assign MAU_busy = (state_q == BURST);
    assign MAU_done = done_q;
    assign MAU_wrap = wrap_q;

endmodule

// File: tb/tb_memory_address_unit.sv
// Bench: three unit configurations share one stimulus stream and are checked against an arithmetic model.
module tb_memory_address_unit;

    localparam int NI = 3;

    function automatic int str_of(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    function automatic int wen_of(input int g);
        return (g == 2) ? 0 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst, wr, inc, dec, start;
    logic [7:0] din, lo, hi;
    logic [3:0] len;

    logic [NI-1:0][7:0] out;
    logic [NI-1:0]      busy, done, wrap;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        memory_address_unit #(
            .ADDR_W (8),
            .STRIDE (str_of(g)),
            .LEN_W  (4),
            .WRAP_EN(wen_of(g))
        ) u_dut (
            .MAU_clk        (clk),
            .MAU_rst        (rst),
            .MAU_in         (din),
            .MAU_wr_en      (wr),
            .MAU_inc_en     (inc),
            .MAU_dec_en     (dec),
            .MAU_burst_start(start),
            .MAU_burst_len  (len),
            .MAU_win_lo     (lo),
            .MAU_win_hi     (hi),
            .MAU_out        (out[g]),
            .MAU_busy       (busy[g]),
            .MAU_done       (done[g]),
            .MAU_wrap       (wrap[g])
        );
    end

    // Model: address as a plain integer, steps computed with ordinary arithmetic.
    int m_addr[NI];
    int m_rem[NI];
    bit m_busy[NI], m_done[NI], m_wrap[NI];
    int inc_n[NI], dec_n[NI];
    bit inc_w[NI], dec_w[NI];

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;

    function automatic void mstep(input int a, input bit dn, input int s, input int we,
                                  input int wlo, input int whi, output int n, output bit w);
        int t;
        t = dn ? a - s : a + s;
        if (we != 0 && wlo <= whi) begin
            if (!dn && t > whi)     begin n = wlo; w = 1'b1; end
            else if (dn && t < wlo) begin n = whi; w = 1'b1; end
            else                    begin n = t;   w = 1'b0; end
        end else if (t < 0)   begin n = t + 256; w = 1'b1; end
        else if (t > 255)     begin n = t - 256; w = 1'b1; end
        else                  begin n = t;       w = 1'b0; end
    endfunction

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            inc_n[i] = 0; inc_w[i] = 1'b0; dec_n[i] = 0; dec_w[i] = 1'b0;
            mstep(m_addr[i], 1'b0, str_of(i), wen_of(i), int'(lo), int'(hi), inc_n[i], inc_w[i]);
            mstep(m_addr[i], 1'b1, str_of(i), wen_of(i), int'(lo), int'(hi), dec_n[i], dec_w[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_addr[i] <= 0; m_busy[i] <= 1'b0; m_rem[i] <= 0; m_done[i] <= 1'b0; m_wrap[i] <= 1'b0;
            end else if (wr) begin
                m_addr[i] <= int'(din); m_busy[i] <= 1'b0; m_rem[i] <= 0; m_done[i] <= 1'b0; m_wrap[i] <= 1'b0;
            end else if (m_busy[i]) begin
                m_addr[i] <= inc_n[i];
                m_wrap[i] <= inc_w[i];
                m_rem[i]  <= m_rem[i] - 1;
                m_busy[i] <= (m_rem[i] > 1);
                m_done[i] <= (m_rem[i] == 1);
            end else begin
                m_done[i] <= 1'b0;
                m_wrap[i] <= 1'b0;
                if (start && len != 0) begin
                    m_busy[i] <= 1'b1;
                    m_rem[i]  <= int'(len);
                end else if (inc) begin
                    m_addr[i] <= inc_n[i]; m_wrap[i] <= inc_w[i];
                end else if (dec) begin
                    m_addr[i] <= dec_n[i]; m_wrap[i] <= dec_w[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if ({out[i], busy[i], done[i], wrap[i]} !== {8'(m_addr[i]), m_busy[i], m_done[i], m_wrap[i]}) begin
                    n_err++;
                    $display("FAIL cycle dut%0d @%0t: got out=%02h busy=%b done=%b wrap=%b, want out=%02h busy=%b done=%b wrap=%b",
                             i, $time, out[i], busy[i], done[i], wrap[i],
                             8'(m_addr[i]), m_busy[i], m_done[i], m_wrap[i]);
                end
            end
        end
    end

    // Hand-computed expectations pinning the model.
    task automatic lit(input string nm, input int i, input int a, input bit b, input bit d, input bit w);
        n_vec++;
        if (m_addr[i] != a || m_busy[i] != b || m_done[i] != d || m_wrap[i] != w) begin
            n_err++;
            $display("FAIL %s dut%0d: got out=%02h busy=%b done=%b wrap=%b, want out=%02h busy=%b done=%b wrap=%b",
                     nm, i, m_addr[i], m_busy[i], m_done[i], m_wrap[i], a, b, d, w);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        wr = 1'b0; inc = 1'b0; dec = 1'b0; start = 1'b0; len = 4'd0;
    endtask

    task automatic load(input logic [7:0] v);
        wr = 1'b1; din = v; tick(); wr = 1'b0;
    endtask

    initial begin
        clr(); rst = 1'b1; din = 8'h00; lo = 8'h00; hi = 8'hFF;
        tick();
        rst = 1'b0; armed = 1'b1;
        lit("reset", 0, 'h00, 0, 0, 0);
        lit("reset", 2, 'h00, 0, 0, 0);

        load(8'h3C);
        lit("load", 0, 'h3C, 0, 0, 0);
        lit("load", 2, 'h3C, 0, 0, 0);

        // Windowed burst, STRIDE=4.
        lo = 8'h10; hi = 8'h1F;
        load(8'h10);
        start = 1'b1; len = 4'd5; tick(); clr();
        lit("burst E0", 0, 'h10, 1, 0, 0);
        tick(); lit("burst E1", 0, 'h14, 1, 0, 0);
        tick(); lit("burst E2", 0, 'h18, 1, 0, 0);
        tick(); lit("burst E3", 0, 'h1C, 1, 0, 0);
        tick(); lit("burst E4", 0, 'h10, 1, 0, 1);
        tick(); lit("burst E5", 0, 'h14, 0, 1, 0);
        lit("burst E5", 1, 'h15, 0, 1, 0);
        tick(); lit("burst after", 0, 'h14, 0, 0, 0);

        // Decrement/increment across window edges.
        lo = 8'h20; hi = 8'h2F;
        load(8'h20);
        dec = 1'b1; tick(); clr();
        lit("dec wrap", 1, 'h2F, 0, 0, 1);
        lit("dec nowin", 2, 'h1F, 0, 0, 0);
        inc = 1'b1; tick(); clr();
        lit("inc wrap", 1, 'h20, 0, 0, 1);
        tick(); lit("wrap clears", 1, 'h20, 0, 0, 0);

        // Natural wrap; inverted window falls back to modulo.
        lo = 8'hF0; hi = 8'h0F;
        load(8'hFF);
        inc = 1'b1; tick(); clr();
        lit("nat inc", 2, 'h00, 0, 0, 1);
        lit("inv inc", 0, 'h03, 0, 0, 1);
        dec = 1'b1; tick(); clr();
        lit("nat dec", 2, 'hFF, 0, 0, 1);
        lit("inv dec", 0, 'hFF, 0, 0, 1);

        // Abort a burst with a load at beat 3.
        lo = 8'h00; hi = 8'hFF;
        load(8'h00);
        start = 1'b1; len = 4'd7; tick(); clr();
        tick(); tick();
        lit("abort pre", 0, 'h08, 1, 0, 0);
        wr = 1'b1; din = 8'h80; tick(); clr();
        lit("abort", 0, 'h80, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick(); lit("abort no done", 0, 'h80, 0, 0, 0);
        end

        // inc_en held during burst is ignored; restart accepted on done cycle.
        load(8'h00);
        start = 1'b1; len = 4'd3; inc = 1'b1; tick(); start = 1'b0;
        lit("hold E0", 0, 'h00, 1, 0, 0);
        tick(); lit("hold E1", 0, 'h04, 1, 0, 0);
        tick(); lit("hold E2", 0, 'h08, 1, 0, 0);
        tick(); lit("hold E3", 0, 'h0C, 0, 1, 0);
        clr(); start = 1'b1; len = 4'd2; tick(); clr();
        lit("restart", 0, 'h0C, 1, 0, 0);
        tick(); tick(); lit("restart end", 0, 'h14, 0, 1, 0);

        // Zero-length burst is ignored.
        start = 1'b1; len = 4'd0; tick(); clr();
        lit("len0", 0, 'h14, 0, 0, 0);
        tick(); lit("len0 no done", 0, 'h14, 0, 0, 0);

        // inc+dec together increments.
        load(8'h05);
        inc = 1'b1; dec = 1'b1; tick(); clr();
        lit("inc+dec", 1, 'h06, 0, 0, 0);
        lit("inc+dec", 0, 'h09, 0, 0, 0);

        // Load beats burst_start.
        wr = 1'b1; din = 8'h40; start = 1'b1; len = 4'd3; tick(); clr();
        lit("wr+start", 0, 'h40, 0, 0, 0);
        tick(); lit("wr+start idle", 0, 'h40, 0, 0, 0);

        // Reset mid-burst.
        start = 1'b1; len = 4'd6; tick(); clr();
        tick(); lit("pre rst", 0, 'h44, 1, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        lit("rst mid", 0, 'h00, 0, 0, 0);
        tick(); tick(); lit("rst no done", 0, 'h00, 0, 0, 0);

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
